// File: rtl/fact_pkg.sv
// fact_pkg: register map, control/status bit positions and FSM states shared by the factorial block.
package fact_pkg;
  localparam logic [1:0] A_N = 2'd0, A_CTRL = 2'd1, A_STATUS = 2'd2, A_RESULT = 2'd3;
  localparam int GO_BIT = 0, IE_BIT = 1, W1C_BIT = 0;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/fact_core.sv
// fact_core: iterative factorial FSM, one multiply per cycle, with overflow detection.
module fact_core
  import fact_pkg::*;
#(
  parameter int N_W = 4,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [N_W-1:0]   n,
  output logic             busy,
  output logic             done_set,
  output logic             err_set,
  output logic [RES_W-1:0] result
);
  localparam int P_W = RES_W + N_W;
  state_t state, state_nxt;
  logic [RES_W-1:0] acc, acc_nxt;
  logic [N_W-1:0] cnt, cnt_nxt;
  logic [P_W-1:0] prod;
  assign result = acc;
  always_comb begin
    prod = P_W'(acc) * P_W'(cnt);
    busy = state == BUSY;
    done_set = busy && cnt <= N_W'(1);
    err_set = busy && !done_set && |prod[P_W-1:RES_W];
    state_nxt = state;
    acc_nxt = acc;
    cnt_nxt = cnt;
    if (!busy && go) begin
      state_nxt = BUSY;
      acc_nxt = RES_W'(1);
      cnt_nxt = n;
    end else if (done_set || err_set) state_nxt = IDLE;
    else if (busy) begin
      acc_nxt = prod[RES_W-1:0];
      cnt_nxt = cnt - N_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      acc <= acc_nxt;
      cnt <= cnt_nxt;
    end
endmodule

// File: rtl/fact_mmio.sv
// fact_mmio: register front end for fact_core with sticky done/err flags and a level interrupt.
module fact_mmio
  import fact_pkg::*;
#(
  parameter int N_W = 4,
  parameter int RES_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  a,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);
  logic [N_W-1:0] n_q;
  logic [RES_W-1:0] res_q, core_res;
  logic ie, done, err, busy, done_set, err_set, go, go_acc, w1c, unused_wd;
  assign go = we && a == A_CTRL && wd[GO_BIT];
  assign go_acc = go && !busy;
  assign w1c = we && a == A_STATUS && wd[W1C_BIT];
  assign irq = done & ie;
  assign unused_wd = ^wd;
  fact_core #(.N_W(N_W), .RES_W(RES_W)) u_core (
    .clk(clk), .rst(rst), .go(go), .n(n_q),
    .busy(busy), .done_set(done_set), .err_set(err_set), .result(core_res)
  );
  // Completion/overflow sets take priority over a same-edge clear.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      n_q <= '0;
      ie <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      res_q <= '0;
    end else begin
      if (we && a == A_N) n_q <= wd[N_W-1:0];
      if (we && a == A_CTRL) ie <= wd[IE_BIT];
      done <= done_set || err_set || (done && !go_acc && !w1c);
      err <= err_set || (err && !go_acc && !w1c);
      if (done_set) res_q <= core_res;
    end
  always_comb
    rd = a == A_N ? 32'(n_q) :
         a == A_CTRL ? {30'b0, ie, busy} :
         a == A_STATUS ? {29'b0, busy, err, done} : 32'(res_q);
endmodule

// File: tb/tb_fact_mmio.sv
// tb_fact_mmio: directed scoreboard bench for fact_mmio with a reference factorial model.
module tb_fact_mmio;
  logic clk = 1'b0, rst, we, irq;
  logic [1:0] a;
  logic [31:0] wd, rd;
  int vectors = 0, miscompares = 0, cyc;
  logic [31:0] exp_q[$];
  logic err_q[$];
  int lat_q[$];
  logic [31:0] last_res = 0;
  logic ie_v = 1'b0;

  always #20 clk = ~clk;

  fact_mmio dut (.clk(clk), .rst(rst), .a(a), .we(we), .wd(wd), .rd(rd), .irq(irq));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    a = addr; wd = data; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [1:0] addr, input logic [31:0] expv);
    a = addr;
    #1 check(tag, rd, expv);
  endtask

  task automatic wait_done(output int c);
    c = 0;
    a = 2'd2;
    #1;
    while (!rd[0] && c < 100) begin
      @(negedge clk);
      c++;
      #1;
    end
  endtask

  // Returns {overflow, value}; on overflow the previous RESULT is expected to remain.
  function automatic logic [32:0] model(input int n, input logic [31:0] prev);
    longint unsigned acc = 1;
    for (int c = n; c > 1; c--) begin
      acc = acc * longint'(c);
      if (acc > 64'hFFFF_FFFF) return {1'b1, prev};
    end
    return {1'b0, acc[31:0]};
  endfunction

  task automatic run_job(input string tag, input int n);
    logic [32:0] r;
    logic [31:0] e;
    logic ef;
    int lat;
    wr(2'd0, 32'(n));
    wr(2'd1, {30'b0, ie_v, 1'b1});
    r = model(n, last_res);
    exp_q.push_back(r[31:0]);
    err_q.push_back(r[32]);
    lat_q.push_back(n > 1 ? n : 1);
    wait_done(cyc);
    e = exp_q.pop_front();
    ef = err_q.pop_front();
    lat = lat_q.pop_front();
    rdchk({tag, "_status"}, 2'd2, {30'b0, ef, 1'b1});
    if (!ef) check({tag, "_latency"}, 32'(cyc), 32'(lat));
    rdchk({tag, "_result"}, 2'd3, e);
    last_res = e;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; a = 2'd0; wd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdchk("rst_n", 2'd0, 0);
    rdchk("rst_ctrl", 2'd1, 0);
    rdchk("rst_status", 2'd2, 0);
    rdchk("rst_result", 2'd3, 0);
    check("rst_irq", 32'(irq), 0);
    @(negedge clk);
    run_job("n5", 5);
    run_job("n0", 0);
    run_job("n1", 1);
    run_job("n12", 12);
    run_job("n13", 13);
    // go and N rewrite while busy; the ie bit of the ignored go still lands
    wr(2'd0, 3);
    wr(2'd1, 1);
    wr(2'd1, 3);
    wr(2'd0, 7);
    rdchk("busy_ctrl", 2'd1, 3);
    wait_done(cyc);
    check("busy_latency", 32'(cyc), 1);
    rdchk("busy_status", 2'd2, 1);
    rdchk("busy_result", 2'd3, 6);
    rdchk("busy_n", 2'd0, 7);
    check("busy_irq", 32'(irq), 1);
    @(negedge clk);
    rdchk("busy_norestart", 2'd2, 1);
    @(negedge clk);
    wr(2'd2, 1);
    last_res = 6;
    ie_v = 1'b1;
    run_job("n4", 4);
    check("n4_irq", 32'(irq), 1);
    @(negedge clk);
    wr(2'd2, 1);
    rdchk("w1c_status", 2'd2, 0);
    check("w1c_irq", 32'(irq), 0);
    @(negedge clk);
    wr(2'd0, 2);
    wr(2'd1, 3);
    @(negedge clk);
    wr(2'd2, 1);
    rdchk("setwins_status", 2'd2, 1);
    check("setwins_irq", 32'(irq), 1);
    rdchk("setwins_result", 2'd3, 2);
    @(negedge clk);
    wr(2'd2, 1);
    wr(2'd0, 9);
    wr(2'd1, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #2 rdchk("abort_status_async", 2'd2, 0);
    @(negedge clk);
    rst = 1'b0;
    rdchk("abort_result", 2'd3, 0);
    rdchk("abort_n", 2'd0, 0);
    rdchk("abort_ctrl", 2'd1, 0);
    repeat (2) @(negedge clk);
    rdchk("abort_nodone", 2'd2, 0);
    check("abort_irq", 32'(irq), 0);
    @(negedge clk);
    last_res = 0;
    ie_v = 1'b0;
    run_job("n3", 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
